// File: rtl/pa_spsram_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pa_spsram_gen_pkg
// Description : Shared types and helpers for the parametrised single-port
//               SRAM block: FSM state encoding and lane-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pa_spsram_gen_pkg;

   // Controller states: zero-fill engine running, or normal request service.
   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Number of data bits covered by one write-mask lane.
   function automatic int lane_width(input int data_width, input int lanes);
      return data_width / lanes;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pa_spsram_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pa_spsram_gen_if
// Description : Request / response bundle between an SRAM client (master)
//               and the pa_spsram_gen storage block (slave).
//               req_*     : access request, accepted when req_vld & req_ready
//               rdata_vld : one-cycle pulse marking a fresh read result
//               rdata     : read data, held until the next read result
//               init_done : zero-fill finished, block in service
// Revision    : 1.0 - initial release
// ============================================================================
interface pa_spsram_gen_if #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 4
);
   logic                  req_vld;
   logic                  req_ready;
   logic                  req_wr;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [LANES-1:0]      req_wmask;
   logic                  rdata_vld;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  init_done;

   modport master (
      output req_vld, req_wr, req_addr, req_wdata, req_wmask,
      input  req_ready, rdata_vld, rdata, init_done
   );

   modport slave (
      input  req_vld, req_wr, req_addr, req_wdata, req_wmask,
      output req_ready, rdata_vld, rdata, init_done
   );
endinterface
`default_nettype wire

// File: rtl/pa_spsram_gen_array.sv
`default_nettype none
// ============================================================================
// Module      : pa_spsram_gen_array
// Description : Behavioural DEPTH x DATA_WIDTH single-port storage with an
//               SRAM-macro pin set, drop-in replaceable by a hard macro.
//               clk  : clock
//               a    : word address
//               cen  : chip enable, active low
//               gwen : global write enable, active low (1 = read)
//               wen  : per-bit write enable, active low
//               d    : write data
//               q    : read data, one cycle after the read edge
// Revision    : 1.0 - initial release
// ============================================================================
module pa_spsram_gen_array #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32
)(
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] a,
   input  logic                  cen,
   input  logic                  gwen,
   input  logic [DATA_WIDTH-1:0] wen,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);
   localparam int c_depth = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [c_depth];
   logic [DATA_WIDTH-1:0] r_q;

   // Like a real macro: no reset, and the output latch moves only on reads.
   always_ff @(posedge clk) begin
      if (!cen) begin
         if (!gwen) begin
            r_mem[a] <= (r_mem[a] & wen) | (d & ~wen);
         end else begin
            r_q <= r_mem[a];
         end
      end
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/pa_spsram_gen.sv
`default_nettype none
// ============================================================================
// Module      : pa_spsram_gen
// Description : Parametrised single-port SRAM block with request handshake,
//               lane write mask, optional output register and post-reset
//               zero-fill engine.
//               cpuclk   : clock, all state on rising edge
//               cpurst_b : asynchronous reset, active low
//               bus      : request/response bundle (slave side)
//               Read latency after the accepting edge: 1 + OUT_REG cycles.
//               DATA_WIDTH must be a multiple of LANES.
// Revision    : 1.0 - initial release
// ============================================================================
module pa_spsram_gen
   import pa_spsram_gen_pkg::*;
#(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 4,
   parameter int OUT_REG    = 0,
   parameter int INIT_EN    = 1
)(
   input  logic           cpuclk,
   input  logic           cpurst_b,
   pa_spsram_gen_if.slave bus
);
   localparam int                  c_depth     = 1 << ADDR_WIDTH;
   localparam int                  c_lane_w    = lane_width(DATA_WIDTH, LANES);
   localparam logic [ADDR_WIDTH:0] c_last      = (ADDR_WIDTH+1)'(c_depth - 1);
   localparam state_t              c_rst_state = (INIT_EN != 0) ? ST_INIT : ST_RUN;

   state_t                r_state;
   logic [ADDR_WIDTH:0]   r_cnt;
   logic                  r_ready;
   logic                  r_init_done;

   logic                  w_init_wr;
   logic                  w_acc;
   logic                  w_rd_acc;
   logic                  w_cen;
   logic                  w_gwen;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_d;
   logic [DATA_WIDTH-1:0] w_bmask;
   logic [DATA_WIDTH-1:0] w_wen;
   logic [DATA_WIDTH-1:0] w_q;

   logic                  r_q_vld;
   logic                  r_s1_vld;
   logic [DATA_WIDTH-1:0] r_s1_dat;

   // ------------------------------------------------------------------------
   // Zero-fill FSM. The counter carries one spare bit so the terminal compare
   // never relies on address wrap.
   // ------------------------------------------------------------------------
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_state     <= c_rst_state;
         r_cnt       <= '0;
         r_ready     <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_last) begin
                  r_state     <= ST_RUN;
                  r_ready     <= 1'b1;
                  r_init_done <= 1'b1;
               end
            end
            default: begin
               r_ready     <= 1'b1;
               r_init_done <= 1'b1;
            end
         endcase
      end
   end

   // The array has no reset pin, so zero-fill writes are held off while reset
   // is asserted to keep the contents untouched until the engine really runs.
   assign w_init_wr = (r_state == ST_INIT) & cpurst_b;
   assign w_acc     = bus.req_vld & r_ready;
   assign w_rd_acc  = w_acc & ~bus.req_wr;

   // ------------------------------------------------------------------------
   // Request mux and macro-style enables
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_bmask[gi*c_lane_w +: c_lane_w] = {c_lane_w{bus.req_wmask[gi]}};
   end

   assign w_cen  = ~(w_init_wr | w_acc);
   assign w_gwen = ~(w_init_wr | (w_acc & bus.req_wr));
   assign w_addr = w_init_wr ? r_cnt[ADDR_WIDTH-1:0] : bus.req_addr;
   assign w_d    = w_init_wr ? '0 : bus.req_wdata;
   assign w_wen  = w_init_wr ? '0 : ~w_bmask;

   pa_spsram_gen_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_array (
      .clk  (cpuclk),
      .a    (w_addr),
      .cen  (w_cen),
      .gwen (w_gwen),
      .wen  (w_wen),
      .d    (w_d),
      .q    (w_q)
   );

   // ------------------------------------------------------------------------
   // Read return path. The array output is captured into a resettable stage
   // so rdata reads zero after reset and in-flight reads are dropped.
   // ------------------------------------------------------------------------
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_q_vld  <= 1'b0;
         r_s1_vld <= 1'b0;
         r_s1_dat <= '0;
      end else begin
         r_q_vld  <= w_rd_acc;
         r_s1_vld <= r_q_vld;
         if (r_q_vld) begin
            r_s1_dat <= w_q;
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic                  r_s2_vld;
      logic [DATA_WIDTH-1:0] r_s2_dat;

      always_ff @(posedge cpuclk or negedge cpurst_b) begin
         if (!cpurst_b) begin
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
         end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
               r_s2_dat <= r_s1_dat;
            end
         end
      end

      assign bus.rdata_vld = r_s2_vld;
      assign bus.rdata     = r_s2_dat;
   end else begin : g_out_direct
      assign bus.rdata_vld = r_s1_vld;
      assign bus.rdata     = r_s1_dat;
   end

   assign bus.req_ready = r_ready;
   assign bus.init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_pa_spsram_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pa_spsram_gen
// Description : Self-checking bench for pa_spsram_gen. Three instances share
//               one stimulus stream: (a) latency 1 with zero-fill, (b) latency
//               2 with zero-fill, (c) latency 1 without zero-fill. A lane-level
//               memory model with a per-bit "known" mask predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pa_spsram_gen;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int LN    = 4;
   localparam int DEPTH = 16;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic [31:0] km;
   } rd_t;

   logic        clk;
   logic        rst_n;
   logic        req_vld;
   logic        req_wr;
   logic [3:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wmask;

   int total;
   int bad;
   int edges;

   int outreg [3] = '{0, 1, 0};
   int rdylat [3] = '{DEPTH, DEPTH, 1};
   int initen [3] = '{1, 1, 0};

   logic [31:0] mem    [3][DEPTH];
   logic [31:0] known  [3][DEPTH];
   rd_t         pq     [3][$];
   logic [31:0] exp_rd [3];
   logic [31:0] exp_km [3];

   logic        o_vld [3];
   logic [31:0] o_rd  [3];
   logic        o_rdy [3];
   logic        o_idn [3];

   pa_spsram_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN)) if_a ();
   pa_spsram_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN)) if_b ();
   pa_spsram_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN)) if_c ();

   assign if_a.req_vld = req_vld;  assign if_b.req_vld = req_vld;  assign if_c.req_vld = req_vld;
   assign if_a.req_wr  = req_wr;   assign if_b.req_wr  = req_wr;   assign if_c.req_wr  = req_wr;
   assign if_a.req_addr  = req_addr;  assign if_b.req_addr  = req_addr;  assign if_c.req_addr  = req_addr;
   assign if_a.req_wdata = req_wdata; assign if_b.req_wdata = req_wdata; assign if_c.req_wdata = req_wdata;
   assign if_a.req_wmask = req_wmask; assign if_b.req_wmask = req_wmask; assign if_c.req_wmask = req_wmask;

   assign o_vld[0] = if_a.rdata_vld; assign o_rd[0] = if_a.rdata;
   assign o_rdy[0] = if_a.req_ready; assign o_idn[0] = if_a.init_done;
   assign o_vld[1] = if_b.rdata_vld; assign o_rd[1] = if_b.rdata;
   assign o_rdy[1] = if_b.req_ready; assign o_idn[1] = if_b.init_done;
   assign o_vld[2] = if_c.rdata_vld; assign o_rd[2] = if_c.rdata;
   assign o_rdy[2] = if_c.req_ready; assign o_idn[2] = if_c.init_done;

   pa_spsram_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN), .OUT_REG(0), .INIT_EN(1))
      u_dut_a (.cpuclk(clk), .cpurst_b(rst_n), .bus(if_a));
   pa_spsram_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN), .OUT_REG(1), .INIT_EN(1))
      u_dut_b (.cpuclk(clk), .cpurst_b(rst_n), .bus(if_b));
   pa_spsram_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN), .OUT_REG(0), .INIT_EN(0))
      u_dut_c (.cpuclk(clk), .cpurst_b(rst_n), .bus(if_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Compare every instance against the model for the current cycle.
   task automatic compare();
      string nm;
      logic  ev;
      logic  er;
      for (int d = 0; d < 3; d++) begin
         nm = (d == 0) ? "a" : (d == 1) ? "b" : "c";
         ev = 1'b0;
         if (pq[d].size() > 0 && pq[d][0].due == edges) begin
            ev        = 1'b1;
            exp_rd[d] = pq[d][0].data;
            exp_km[d] = pq[d][0].km;
            void'(pq[d].pop_front());
         end
         er = rst_n && (edges >= rdylat[d]);
         chk({nm, ".rdata_vld"}, 32'(o_vld[d]), 32'(ev));
         chk({nm, ".rdata"}, o_rd[d] & exp_km[d], exp_rd[d] & exp_km[d]);
         chk({nm, ".req_ready"}, 32'(o_rdy[d]), 32'(er));
         chk({nm, ".init_done"}, 32'(o_idn[d]), 32'(er));
      end
   endtask

   // One clock edge: apply the request to the model, then check outputs.
   task automatic step();
      int cur;
      @(posedge clk);
      if (rst_n) begin
         cur = edges + 1;
         for (int d = 0; d < 3; d++) begin
            if (req_vld && edges >= rdylat[d]) begin
               if (req_wr) begin
                  for (int l = 0; l < 4; l++) begin
                     if (req_wmask[l]) begin
                        mem[d][req_addr][l*8 +: 8]   = req_wdata[l*8 +: 8];
                        known[d][req_addr][l*8 +: 8] = 8'hff;
                     end
                  end
               end else begin
                  pq[d].push_back('{due: cur + 1 + outreg[d],
                                    data: mem[d][req_addr],
                                    km: known[d][req_addr]});
               end
            end
         end
         edges = cur;
         for (int d = 0; d < 3; d++) begin
            if (initen[d] != 0 && edges == DEPTH) begin
               for (int a = 0; a < DEPTH; a++) begin
                  mem[d][a]   = '0;
                  known[d][a] = '1;
               end
            end
         end
      end
      #1;
      compare();
   endtask

   task automatic drive(input logic v, input logic w, input logic [3:0] a,
                        input logic [31:0] wd, input logic [3:0] m);
      req_vld   = v;
      req_wr    = w;
      req_addr  = a;
      req_wdata = wd;
      req_wmask = m;
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      edges = 0;
      for (int d = 0; d < 3; d++) begin
         pq[d].delete();
         exp_rd[d] = '0;
         exp_km[d] = '1;
      end
      #1;
      compare();
   endtask

   task automatic random_traffic(input int n);
      for (int i = 0; i < n; i++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int d = 0; d < 3; d++) begin
         for (int a = 0; a < DEPTH; a++) begin
            mem[d][a]   = '0;
            known[d][a] = '0;
         end
      end
      req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
      #2;
      do_reset();
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
      rst_n = 1'b1;

      // Zero-fill window: requests are ignored by a/b, served by c.
      random_traffic(DEPTH);
      for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b0, 4'(a), 32'h0, 4'h0);

      // Lane-masked write merge.
      drive(1'b1, 1'b1, 4'd5, 32'h1234_5678, 4'b1111);
      drive(1'b1, 1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101);
      drive(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);

      // Back-to-back reads.
      drive(1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
      drive(1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
      drive(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);

      // Write-then-read, idle and empty-mask write keep rdata.
      drive(1'b1, 1'b1, 4'd7, 32'hDEAD_BEEF, 4'hF);
      drive(1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
      drive(1'b1, 1'b1, 4'd7, 32'h5555_AAAA, 4'h0);
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
      drive(1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);

      random_traffic(300);

      // Reset with reads in flight.
      drive(1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
      do_reset();
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
      rst_n = 1'b1;

      // Reset again part-way through zero-fill (counter at 9).
      random_traffic(9);
      do_reset();
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
      rst_n = 1'b1;

      random_traffic(DEPTH);
      for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b0, 4'(a), 32'h0, 4'h0);
      random_traffic(300);
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
